hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- ID-stage hazard controller. It detects the hazards that EX-stage forwarding cannot resolve and converts them into stall, bubble and flush controls for the pipeline registers.
- Covers three hazard types:
  - load-use: a load in EX whose value is needed by the instruction in ID;
  - taken-branch flush, resolved in EX;
  - multi-cycle memory/MMIO wait in MEM, with a timeout.
- Forwarding never takes a load result from MEM, so one bubble is always enough: the loaded value is then forwarded from WB.

Parameters:
- MEM_TIMEOUT, 64: maximum consecutive MEM wait cycles before a forced release.
- CNT_W, 16: width of the saturating stall-cycle performance counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- read_reg_idx_1_ID  in  5  rs1 index of the instruction in ID
- read_reg_idx_2_ID  in  5  rs2 index of the instruction in ID
- read_reg_1_used_ID  in  1  the ID instruction actually reads rs1
- read_reg_2_used_ID  in  1  the ID instruction actually reads rs2
- write_reg_idx_EX  in  5  destination of the instruction in EX
- write_reg_flag_EX  in  1  the EX instruction writes a register
- mem_to_reg_flag_EX  in  1  the EX instruction is a load
- branch_taken_EX  in  1  branch/jump taken, resolved in EX
- mem_access_MEM  in  1  the MEM instruction accesses memory/MMIO
- mem_ready_MEM  in  1  memory/MMIO access completes this cycle
- stall_IF_flag  out  1  hold the PC
- stall_ID_flag  out  1  hold IF/ID
- bubble_EX_flag  out  1  load a NOP into ID/EX
- flush_ID_flag  out  1  load a NOP into IF/ID
- stall_MEM_flag  out  1  hold PC, IF/ID, ID/EX and EX/MEM; bubble into MEM/WB
- hazard_state  out  2  current FSM state
- mem_timeout_flag  out  1  sticky: a MEM wait hit the timeout
- stall_cycle_cnt  out  CNT_W  saturating count of cycles with any stall

Behaviour:
- Reset: asynchronous, active-low. Clocked elements use one clock; reset is asynchronous active-low on rst_n.
  - On reset, state goes to RUN and all counters and flags go to 0.
  - All outputs are 0 while rst_n is low, including the combinational ones.
- Timing: all control outputs are combinational from the current inputs and registered state, valid in the same cycle. Pipeline registers act on them at the next rising edge.
- Hazard terms:
  - lu = write_reg_flag_EX & mem_to_reg_flag_EX & write_reg_idx_EX != 0 & ((read_reg_1_used_ID & idx1 == write_reg_idx_EX) | (read_reg_2_used_ID & idx2 == write_reg_idx_EX)).
  - mw = mem_access_MEM & !mem_ready_MEM & (wait_cnt != MEM_TIMEOUT).
- Priority: mw > branch > lu.
  - mw: stall_MEM_flag = 1 only. All other outputs are 0, and branch/lu are deferred because the pipeline is frozen.
  - Else branch_taken_EX: flush_ID_flag = 1 and bubble_EX_flag = 1. Stalls are 0; a load-use against a flushed instruction is ignored.
  - Else lu: stall_IF_flag = 1, stall_ID_flag = 1, bubble_EX_flag = 1, for exactly one cycle. After the edge the load sits in MEM, EX holds the bubble, and lu deasserts naturally.
- FSM, registered, with hazard_state encoding RUN = 0, LU = 1, MEMW = 2, and 3 unused (recover to RUN):
  - Next state is MEMW if mw.
  - Else LU if lu & !branch_taken_EX.
  - Else RUN.
  - hazard_state reflects the hazard serviced in the previous cycle.
- wait_cnt, width clog2(MEM_TIMEOUT + 1):
  - increments each cycle mw is true;
  - clears when mem_access_MEM is 0 or mem_ready_MEM is 1.
- Timeout:
  - When wait_cnt == MEM_TIMEOUT, mw is forced to 0 for that cycle: the access is released with whatever data is present.
  - mem_timeout_flag is set and stays set until reset.
  - wait_cnt clears on the following cycle.
  - MEM_TIMEOUT = N therefore gives at most N stall cycles per access.
- mem_ready_MEM in the same cycle as mem_access_MEM means no stall (zero wait).
- stall_cycle_cnt increments when stall_IF_flag | stall_MEM_flag is 1, and saturates at all-ones.
- Register index 0 never creates a load-use hazard.
- Reset asserted mid-stall drops all outputs immediately. The first cycle after release is RUN with counters at 0.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - hazard_state encodings RUN, LU, MEMW;
  - REG_IDX_W = 5;
  - the default MEM_TIMEOUT value.
- One natural sub-module, mem_wait_timer. It owns wait_cnt, the timeout compare and mem_timeout_flag, and exports mw.
- Load-use detection and the priority logic stay in the top module.

Test Plan:
- Load-use: EX = load x5, ID reads rs1 = x5 with used = 1 → stall_IF = stall_ID = bubble_EX = 1 for one cycle; the next cycle all are 0 and hazard_state = LU.
- No load-use cases: EX = load x0 with ID rs2 = x0 → no stall. EX = load x7 with ID rs1 = x7 but used = 0 → no stall.
- Branch vs load-use: branch_taken_EX = 1 together with a load-use condition → flush_ID = 1, bubble_EX = 1, stall_IF = 0, stall_count unchanged.
- MEM wait: mem_access = 1 with mem_ready low for 3 cycles then high → stall_MEM_flag = 1 for exactly 3 cycles, stall_cycle_cnt = 3, no timeout.
- Timeout: MEM_TIMEOUT = 4, mem_ready held low → stall_MEM_flag high for 4 cycles then low for 1; mem_timeout_flag = 1 and stays 1 after mem_ready rises.
- Reset mid-stall: rst_n pulled low during MEMW with wait_cnt = 2 → all outputs 0 asynchronously; after release, state = RUN, counters = 0, and a new 1-cycle wait stalls exactly 1 cycle.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: hazard FSM encodings and the
// default widths/limits used by the ID-stage hazard controller.
package pipeline_ctrl_pkg;

  localparam int REG_IDX_W           = 5;
  localparam int MEM_TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LU   = 2'd1,
    ST_MEMW = 2'd2
  } hazard_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive MEM wait cycles and releases a stuck access once
// MEM_TIMEOUT cycles have elapsed, latching a sticky timeout flag.
module mem_wait_timer
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_mem_access,
  input  logic i_mem_ready,
  output logic o_mw,
  output logic o_timeout_flag
);

  localparam int                WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] LIMIT  = WAIT_W'(MEM_TIMEOUT);

  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_next;
  logic              r_timeout_flag;
  logic              w_waiting;
  logic              w_limit_hit;

  assign w_waiting   = i_mem_access & ~i_mem_ready;
  assign w_limit_hit = (r_wait_cnt == LIMIT);
  assign o_mw        = w_waiting & ~w_limit_hit;

  // Any cycle that is not an active wait (idle, ready, or the release cycle) clears the count.
  always_comb begin
    w_wait_cnt_next = {WAIT_W{1'b0}};
    if (o_mw) begin
      w_wait_cnt_next = r_wait_cnt + WAIT_W'(1);
    end else begin
      w_wait_cnt_next = {WAIT_W{1'b0}};
    end
  end

  // Wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt     <= {WAIT_W{1'b0}};
      r_timeout_flag <= 1'b0;
    end else begin
      r_wait_cnt <= w_wait_cnt_next;
      if (w_waiting && w_limit_hit) begin
        r_timeout_flag <= 1'b1;
      end else begin
        r_timeout_flag <= r_timeout_flag;
      end
    end
  end

  assign o_timeout_flag = r_timeout_flag;

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard controller: turns load-use, taken-branch and MEM-wait
// hazards into stall/bubble/flush controls, with priority mw > branch > lu.
module hazard_stall_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_IDX_W-1:0] read_reg_idx_1_ID,
  input  logic [REG_IDX_W-1:0] read_reg_idx_2_ID,
  input  logic                 read_reg_1_used_ID,
  input  logic                 read_reg_2_used_ID,
  input  logic [REG_IDX_W-1:0] write_reg_idx_EX,
  input  logic                 write_reg_flag_EX,
  input  logic                 mem_to_reg_flag_EX,
  input  logic                 branch_taken_EX,
  input  logic                 mem_access_MEM,
  input  logic                 mem_ready_MEM,
  output logic                 stall_IF_flag,
  output logic                 stall_ID_flag,
  output logic                 bubble_EX_flag,
  output logic                 flush_ID_flag,
  output logic                 stall_MEM_flag,
  output logic [1:0]           hazard_state,
  output logic                 mem_timeout_flag,
  output logic [CNT_W-1:0]     stall_cycle_cnt
);

  hazard_state_e    r_state;
  hazard_state_e    w_next_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_mw;
  logic             w_lu;
  logic             w_timeout_flag;
  logic             w_stall_if;
  logic             w_stall_id;
  logic             w_bubble_ex;
  logic             w_flush_id;
  logic             w_stall_mem;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_mem_access   (mem_access_MEM),
    .i_mem_ready    (mem_ready_MEM),
    .o_mw           (w_mw),
    .o_timeout_flag (w_timeout_flag)
  );

  // x0 is hardwired zero, so a load targeting it never produces a dependency.
  assign w_lu = write_reg_flag_EX & mem_to_reg_flag_EX
              & (write_reg_idx_EX != {REG_IDX_W{1'b0}})
              & ((read_reg_1_used_ID & (read_reg_idx_1_ID == write_reg_idx_EX))
               | (read_reg_2_used_ID & (read_reg_idx_2_ID == write_reg_idx_EX)));

  // Prioritised control outputs; everything is held low while in reset.
  always_comb begin
    w_stall_if  = 1'b0;
    w_stall_id  = 1'b0;
    w_bubble_ex = 1'b0;
    w_flush_id  = 1'b0;
    w_stall_mem = 1'b0;
    if (!rst_n) begin
      w_stall_mem = 1'b0;
    end else if (w_mw) begin
      w_stall_mem = 1'b1;
    end else if (branch_taken_EX) begin
      w_flush_id  = 1'b1;
      w_bubble_ex = 1'b1;
    end else if (w_lu) begin
      w_stall_if  = 1'b1;
      w_stall_id  = 1'b1;
      w_bubble_ex = 1'b1;
    end else begin
      w_stall_if = 1'b0;
    end
  end

  // Next state depends only on the serviced hazard, so the unused code recovers to RUN.
  always_comb begin
    w_next_state = ST_RUN;
    if (w_mw) begin
      w_next_state = ST_MEMW;
    end else if (w_lu && !branch_taken_EX) begin
      w_next_state = ST_LU;
    end else begin
      w_next_state = ST_RUN;
    end
  end

  // State register and saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_stall_cnt <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      if ((w_stall_if || w_stall_mem) && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  assign stall_IF_flag    = w_stall_if;
  assign stall_ID_flag    = w_stall_id;
  assign bubble_EX_flag   = w_bubble_ex;
  assign flush_ID_flag    = w_flush_id;
  assign stall_MEM_flag   = w_stall_mem;
  assign hazard_state     = r_state;
  assign mem_timeout_flag = w_timeout_flag;
  assign stall_cycle_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed table-driven bench for hazard_stall_unit, built with a small
// timeout and narrow stall counter so timeout and saturation are reachable.
module tb_hazard_stall_unit;

  localparam int T_OUT = 4;
  localparam int CW    = 4;

  typedef struct {
    logic [4:0] idx1;
    logic [4:0] idx2;
    logic       u1;
    logic       u2;
    logic [4:0] wd;
    logic       wf;
    logic       mtr;
    logic       br;
    logic       acc;
    logic       rdy;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [4:0] exp_ctrl;
    logic [1:0] exp_state;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic [4:0]    idx1, idx2, wd;
  logic          u1, u2, wf, mtr, br, acc, rdy;
  logic          s_if, s_id, b_ex, f_id, s_mem, t_flag;
  logic [1:0]    h_state;
  logic [CW-1:0] s_cnt;

  int n_vec;
  int n_fail;
  int exp_cnt;

  hazard_stall_unit #(
    .MEM_TIMEOUT (T_OUT),
    .CNT_W       (CW)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .read_reg_idx_1_ID  (idx1),
    .read_reg_idx_2_ID  (idx2),
    .read_reg_1_used_ID (u1),
    .read_reg_2_used_ID (u2),
    .write_reg_idx_EX   (wd),
    .write_reg_flag_EX  (wf),
    .mem_to_reg_flag_EX (mtr),
    .branch_taken_EX    (br),
    .mem_access_MEM     (acc),
    .mem_ready_MEM      (rdy),
    .stall_IF_flag      (s_if),
    .stall_ID_flag      (s_id),
    .bubble_EX_flag     (b_ex),
    .flush_ID_flag      (f_id),
    .stall_MEM_flag     (s_mem),
    .hazard_state       (h_state),
    .mem_timeout_flag   (t_flag),
    .stall_cycle_cnt    (s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    idx1 = v.idx1; idx2 = v.idx2; u1 = v.u1; u2 = v.u2;
    wd = v.wd; wf = v.wf; mtr = v.mtr; br = v.br; acc = v.acc; rdy = v.rdy;
  endtask

  // One pipeline cycle: drive, check combinational controls, clock, check registered state.
  task automatic cyc(input string nm, input in_t v, input logic [4:0] ec, input logic [1:0] es);
    drive(v);
    @(negedge clk);
    chk({nm, ".ctrl"}, int'({s_if, s_id, b_ex, f_id, s_mem}), int'(ec));
    if ((ec[4] || ec[0]) && exp_cnt < 15) exp_cnt++;
    @(posedge clk);
    #1;
    chk({nm, ".state"}, int'(h_state), int'(es));
    chk({nm, ".cnt"}, int'(s_cnt), exp_cnt);
  endtask

  vec_t tbl[12];
  in_t  none_v, wait_v, rdy_v, wait_br_v, lu_v;

  initial begin
    n_vec = 0;
    n_fail = 0;
    exp_cnt = 0;
    none_v    = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    lu_v      = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    wait_v    = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rdy_v     = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    wait_br_v = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    tbl[0]  = '{"lu_rs1_x5",     lu_v,   5'b11100, 2'd1};
    tbl[1]  = '{"idle_after_lu", none_v, 5'b00000, 2'd0};
    tbl[2]  = '{"load_x0",       '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, 5'b00000, 2'd0};
    tbl[3]  = '{"rs1_unused",    '{5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, 5'b00000, 2'd0};
    tbl[4]  = '{"lu_rs2_x7",     '{5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, 5'b11100, 2'd1};
    tbl[5]  = '{"alu_no_lu",     '{5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}, 5'b00000, 2'd0};
    tbl[6]  = '{"load_nowrite",  '{5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}, 5'b00000, 2'd0};
    tbl[7]  = '{"branch_over_lu", '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}, 5'b00110, 2'd0};
    tbl[8]  = '{"branch_only",   '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}, 5'b00110, 2'd0};
    tbl[9]  = '{"lu_x31",        '{5'd4, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, 5'b11100, 2'd1};
    tbl[10] = '{"no_match",      '{5'd13, 5'd14, 1'b1, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}, 5'b00000, 2'd0};
    tbl[11] = '{"zero_wait_lu",  '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}, 5'b11100, 2'd1};

    // Reset with a live load-use on the inputs: every output must stay low.
    rst_n = 1'b0;
    drive(lu_v);
    #3;
    chk("reset.ctrl", int'({s_if, s_id, b_ex, f_id, s_mem}), 0);
    chk("reset.state", int'(h_state), 0);
    chk("reset.flag", int'(t_flag), 0);
    chk("reset.cnt", int'(s_cnt), 0);
    #4;
    rst_n = 1'b1;
    drive(none_v);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].name, tbl[i].in, tbl[i].exp_ctrl, tbl[i].exp_state);
    end

    // Three-cycle wait; first cycle also carries a branch and a load-use, both deferred.
    cyc("memw1", wait_br_v, 5'b00001, 2'd2);
    cyc("memw2", wait_v, 5'b00001, 2'd2);
    cyc("memw3", wait_v, 5'b00001, 2'd2);
    cyc("memw_done", rdy_v, 5'b00000, 2'd0);
    chk("memw.flag", int'(t_flag), 0);
    chk("memw.cnt_delta", exp_cnt, 7);

    // Timeout: four stall cycles, one forced release, then waiting resumes.
    for (int i = 0; i < 4; i++) cyc("tmo_wait", wait_v, 5'b00001, 2'd2);
    cyc("tmo_release", wait_v, 5'b00000, 2'd0);
    chk("tmo.flag_set", int'(t_flag), 1);
    cyc("tmo_rewait", wait_v, 5'b00001, 2'd2);
    cyc("tmo_ready", rdy_v, 5'b00000, 2'd0);
    chk("tmo.flag_sticky", int'(t_flag), 1);

    // Drive the 4-bit counter past 15 to check saturation.
    for (int i = 0; i < 4; i++) cyc("sat_wait", wait_v, 5'b00001, 2'd2);
    cyc("sat_release", wait_v, 5'b00000, 2'd0);
    cyc("sat_rewait", wait_v, 5'b00001, 2'd2);
    cyc("sat_ready", rdy_v, 5'b00000, 2'd0);
    chk("sat.cnt", int'(s_cnt), 15);

    // Reset in the middle of a MEM wait with wait_cnt = 2.
    cyc("rst_w1", wait_v, 5'b00001, 2'd2);
    cyc("rst_w2", wait_v, 5'b00001, 2'd2);
    drive(wait_v);
    #2;
    chk("rst_mid.pre", int'(s_mem), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.ctrl", int'({s_if, s_id, b_ex, f_id, s_mem}), 0);
    chk("rst_mid.state", int'(h_state), 0);
    chk("rst_mid.flag", int'(t_flag), 0);
    chk("rst_mid.cnt", int'(s_cnt), 0);
    #3;
    rst_n = 1'b1;
    drive(none_v);
    exp_cnt = 0;
    #1;
    chk("rst_rel.state", int'(h_state), 0);
    @(posedge clk);
    #1;
    cyc("post_w1", wait_v, 5'b00001, 2'd2);
    cyc("post_ready", rdy_v, 5'b00000, 2'd0);
    chk("post.cnt", int'(s_cnt), 1);
    // A stale wait count would release before four full stall cycles.
    for (int i = 0; i < 4; i++) cyc("post_long", wait_v, 5'b00001, 2'd2);
    cyc("post_long_rel", wait_v, 5'b00000, 2'd0);
    cyc("post_idle", none_v, 5'b00000, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
